// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-to-decode bus layout and reset PC
package cpu_pkg;

    localparam int FS_TO_DS_BUS_WD = 65;
    localparam int INST_LSB        = 0;
    localparam int PC_LSB          = 32;
    localparam int ADEF_BIT        = 64;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    function automatic logic [FS_TO_DS_BUS_WD-1:0] fs_bus_pack(
        input logic        adef,
        input logic [31:0] pc,
        input logic [31:0] inst
    );
        logic [FS_TO_DS_BUS_WD-1:0] bus;
        bus                  = '0;
        bus[ADEF_BIT]        = adef;
        bus[PC_LSB +: 32]    = pc;
        bus[INST_LSB +: 32]  = inst;
        return bus;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - pre-IF / decode handshake signals of the fetch stage
interface if_stage_if
    import cpu_pkg::*;
#(
    parameter int BUS_WD = FS_TO_DS_BUS_WD
);
    logic              pf_valid;
    logic [31:0]       pf_pc;
    logic              pf_excp_adef;
    logic [31:0]       inst_sram_rdata;
    logic              br_taken_cancel;
    logic              excp_flush;
    logic              ertn_flush;
    logic              ds_allowin;
    logic              fs_stall;
    logic              fs_to_ds_valid;
    logic [BUS_WD-1:0] fs_to_ds_bus;

    modport master (
        output pf_valid, pf_pc, pf_excp_adef, inst_sram_rdata,
        output br_taken_cancel, excp_flush, ertn_flush, ds_allowin,
        input  fs_stall, fs_to_ds_valid, fs_to_ds_bus
    );

    modport slave (
        input  pf_valid, pf_pc, pf_excp_adef, inst_sram_rdata,
        input  br_taken_cancel, excp_flush, ertn_flush, ds_allowin,
        output fs_stall, fs_to_ds_valid, fs_to_ds_bus
    );
endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - DEPTH x WIDTH circular queue with push/pop/clear
module fetch_buf #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 65,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers are exactly PW bits, so the power-of-two depth wraps for free.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (resetn_i && push_i && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage buffer with redirect flush; IF_PERF_CNT_EN adds a stall counter
module if_stage
    import cpu_pkg::*;
#(
    parameter int BUF_DEPTH       = 2,
    parameter int FS_TO_DS_BUS_WD = cpu_pkg::FS_TO_DS_BUS_WD
) (
    input  logic        clk,
    input  logic        resetn,
    if_stage_if.slave   fs_if
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fs_perf_stall_cnt
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic                       armed_q, armed_d;
    logic                       flush, push, pop;
    logic                       buf_full, buf_empty;
    logic [CW-1:0]              buf_count;
    logic [FS_TO_DS_BUS_WD-1:0] buf_head;
    logic [FS_TO_DS_BUS_WD-1:0] wr_entry;

    // SRAM data lags the PC by one cycle out of reset, so the first cycle is skipped.
    assign armed_d = 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) armed_q <= 1'b0;
        else         armed_q <= armed_d;
    end

    assign flush = fs_if.br_taken_cancel | fs_if.excp_flush | fs_if.ertn_flush;

    assign fs_if.fs_to_ds_valid = (buf_count != '0) & ~flush;
    assign pop                  = fs_if.fs_to_ds_valid & fs_if.ds_allowin;
    assign fs_if.fs_stall       = buf_full & ~pop & ~flush;
    assign push                 = armed_q & fs_if.pf_valid & ~fs_if.fs_stall & ~flush;

    assign wr_entry = fs_bus_pack(fs_if.pf_excp_adef, fs_if.pf_pc, fs_if.inst_sram_rdata);

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FS_TO_DS_BUS_WD)
    ) u_fetch_buf (
        .clk_i    (clk),
        .resetn_i (resetn),
        .push_i   (push),
        .pop_i    (pop),
        .clr_i    (flush),
        .data_i   (wr_entry),
        .head_o   (buf_head),
        .count_o  (buf_count),
        .full_o   (buf_full),
        .empty_o  (buf_empty)
    );

    assign fs_if.fs_to_ds_bus = buf_empty ? '0 : buf_head;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    // Counts cycles where pre-IF had a PC ready but was held; flush does not clear it.
    assign perf_cnt_d = perf_cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_cnt_q <= '0;
        end else if (armed_q & fs_if.pf_valid & fs_if.fs_stall) begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign fs_perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector table plus randomized reference-model run for if_stage
module tb_if_stage;
    import cpu_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [31:0] B = RESET_PC;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    if_stage_if bus_if ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_cnt;
`endif

    if_stage #(
        .BUF_DEPTH       (DEPTH),
        .FS_TO_DS_BUS_WD (FS_TO_DS_BUS_WD)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .fs_if  (bus_if)
`ifdef IF_PERF_CNT_EN
        ,
        .fs_perf_stall_cnt (perf_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hdead_beef;
    endfunction

    // Behavioural reference: an ordered list of fetched entries plus an armed bit.
    logic [64:0] mq[$];
    bit          m_armed = 0;
    logic [31:0] m_perf  = 0;
    bit          m_pushed;

    function automatic bit m_flush();
        return bus_if.br_taken_cancel | bus_if.excp_flush | bus_if.ertn_flush;
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0) && !m_flush();
    endfunction

    function automatic bit m_stall();
        bit pop;
        pop = m_valid() && bus_if.ds_allowin;
        return (mq.size() == DEPTH) && !pop && !m_flush();
    endfunction

    task automatic model_step();
        bit pop, st, psh;
        pop = m_valid() && bus_if.ds_allowin;
        st  = m_stall();
        psh = m_armed && bus_if.pf_valid && !st && !m_flush();
        m_pushed = 0;
        if (!resetn) begin
            mq.delete();
            m_armed = 0;
            m_perf  = 0;
        end else begin
            if (m_armed && bus_if.pf_valid && st) m_perf = m_perf + 32'd1;
            if (m_flush()) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (psh) begin
                    mq.push_back({bus_if.pf_excp_adef, bus_if.pf_pc, inst_of(bus_if.pf_pc)});
                    m_pushed = 1;
                end
            end
            m_armed = 1;
        end
    endtask

    task automatic drive(input bit rst, input bit pv, input logic [31:0] pc, input bit adef,
                         input bit br, input bit ex, input bit er, input bit al);
        @(negedge clk);
        resetn                 = rst;
        bus_if.pf_valid        = pv;
        bus_if.pf_pc           = pc;
        bus_if.pf_excp_adef    = adef;
        bus_if.inst_sram_rdata = inst_of(pc);
        bus_if.br_taken_cancel = br;
        bus_if.excp_flush      = ex;
        bus_if.ertn_flush      = er;
        bus_if.ds_allowin      = al;
        #1;
    endtask

    typedef struct {
        bit          rst, pv;
        logic [31:0] pc;
        bit          adef, br, ex, er, al;
        bit          e_v, e_st;
        logic [31:0] e_pc;
        bit          e_adef;
    } vec_t;

    function automatic vec_t mk(bit rst, bit pv, logic [31:0] pc, bit adef, bit br, bit ex,
                                bit er, bit al, bit e_v, bit e_st, logic [31:0] e_pc, bit e_adef);
        vec_t v;
        v.rst = rst; v.pv = pv; v.pc = pc; v.adef = adef;
        v.br = br; v.ex = ex; v.er = er; v.al = al;
        v.e_v = e_v; v.e_st = e_st; v.e_pc = e_pc; v.e_adef = e_adef;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        logic [31:0] pf_pc;
        bit          pv, al, br, ex, er, adef, rst;
        int          src;

        //              rst pv pc        ad br ex er al  v  st exp_pc    ead
        vt.push_back(mk(0, 1, B,         0, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B,         0, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B,         0, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h4,   0, 0, 0, 0, 1,  1, 0, B,        0));
        vt.push_back(mk(1, 1, B+32'h8,   0, 0, 0, 0, 1,  1, 0, B+32'h4,  0));
        vt.push_back(mk(1, 1, B+32'hc,   0, 0, 0, 0, 1,  1, 0, B+32'h8,  0));
        vt.push_back(mk(1, 1, B+32'h10,  0, 0, 0, 0, 0,  1, 0, B+32'hc,  0));
        vt.push_back(mk(1, 1, B+32'h14,  0, 0, 0, 0, 0,  1, 1, B+32'hc,  0));
        vt.push_back(mk(1, 1, B+32'h14,  0, 0, 0, 0, 0,  1, 1, B+32'hc,  0));
        vt.push_back(mk(1, 1, B+32'h14,  0, 0, 0, 0, 0,  1, 1, B+32'hc,  0));
        vt.push_back(mk(1, 1, B+32'h14,  0, 0, 0, 0, 1,  1, 0, B+32'hc,  0));
        vt.push_back(mk(1, 1, B+32'h18,  0, 0, 0, 0, 1,  1, 0, B+32'h10, 0));
        vt.push_back(mk(1, 1, B+32'h1c,  0, 0, 0, 0, 0,  1, 1, B+32'h14, 0));
        vt.push_back(mk(1, 1, B+32'h1c,  0, 1, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h100, 0, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h104, 0, 0, 0, 0, 1,  1, 0, B+32'h100,0));
        vt.push_back(mk(1, 1, B+32'h108, 0, 0, 1, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h200, 0, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h204, 0, 0, 0, 1, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h2,   1, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h400, 0, 0, 0, 0, 1,  1, 0, B+32'h2,  1));
        vt.push_back(mk(1, 1, B+32'h404, 0, 0, 0, 0, 0,  1, 0, B+32'h400,0));
        vt.push_back(mk(1, 1, B+32'h408, 0, 0, 0, 0, 0,  1, 1, B+32'h400,0));
        vt.push_back(mk(0, 1, B+32'h408, 0, 0, 0, 0, 0,  1, 1, B+32'h400,0));
        vt.push_back(mk(1, 1, B,         0, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B,         0, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h4,   0, 0, 0, 0, 1,  1, 0, B,        0));
        vt.push_back(mk(1, 1, B+32'h8,   0, 1, 1, 1, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h500, 0, 0, 0, 0, 1,  0, 0, 32'h0,    0));
        vt.push_back(mk(1, 1, B+32'h504, 0, 0, 0, 0, 1,  1, 0, B+32'h500,0));

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, B, 0, 0, 0, 0, 0);
            model_step();
        end
        check("reset_valid", {64'h0, bus_if.fs_to_ds_valid}, 65'h0);
        check("reset_stall", {64'h0, bus_if.fs_stall}, 65'h0);
        check("reset_bus", bus_if.fs_to_ds_bus, 65'h0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].pv, vt[i].pc, vt[i].adef, vt[i].br, vt[i].ex, vt[i].er, vt[i].al);
            check($sformatf("vec%0d_valid", i), {64'h0, bus_if.fs_to_ds_valid}, {64'h0, vt[i].e_v});
            check($sformatf("vec%0d_stall", i), {64'h0, bus_if.fs_stall}, {64'h0, vt[i].e_st});
            if (vt[i].e_v)
                check($sformatf("vec%0d_bus", i), bus_if.fs_to_ds_bus,
                      {vt[i].e_adef, vt[i].e_pc, inst_of(vt[i].e_pc)});
`ifdef IF_PERF_CNT_EN
            if (i == 10) check("perf_three_stalls", {33'h0, perf_cnt}, 65'd3);
`endif
            model_step();
        end

        // Randomized run: a bench-side pre-IF holds its PC until the stage consumes it.
        pf_pc = B;
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 399) != 0);
            pv   = ($urandom_range(0, 9) != 0);
            al   = ($urandom_range(0, 9) < 7);
            src  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 7)) : 0;
            br   = src[0];
            ex   = src[1];
            er   = src[2];
            adef = ($urandom_range(0, 15) == 0);
            drive(rst, pv, pf_pc, adef, br, ex, er, al);
            check("rnd_valid", {64'h0, bus_if.fs_to_ds_valid}, {64'h0, m_valid()});
            check("rnd_stall", {64'h0, bus_if.fs_stall}, {64'h0, m_stall()});
            if (m_valid()) check("rnd_bus", bus_if.fs_to_ds_bus, mq[0]);
`ifdef IF_PERF_CNT_EN
            check("rnd_perf", {33'h0, perf_cnt}, {33'h0, m_perf});
`endif
            model_step();
            if (!rst)           pf_pc = B;
            else if (src != 0)  pf_pc = B + 32'h1000 + {$urandom_range(0, 255), 2'b00};
            else if (m_pushed)  pf_pc = pf_pc + 32'd4;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
